// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared definitions for the count_ctrl step scheduler.
//   - ST_STOP / ST_RUN / ST_LIMIT : state encoding as seen on state_out
//   - state_t                     : FSM state type built on that encoding
//   - calc_div / calc_tw          : auto-run prescaler divide ratio and its
//                                   counter width
`timescale 1ns/1ps
package count_ctrl_pkg;

  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_LIMIT = 2'b10;

  typedef enum logic [1:0] {
    S_STOP  = ST_STOP,
    S_RUN   = ST_RUN,
    S_LIMIT = ST_LIMIT
  } state_t;

  // Clock cycles between auto-run steps.
  function automatic int calc_div(input int clk_hz, input int step_hz);
    return clk_hz / step_hz;
  endfunction

  // Width of the prescaler counter; at least one bit.
  function automatic int calc_tw(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/count_ctrl_rate.sv
// rate_timer: DIV prescaler for auto-run.
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   en     in  count enable (high only while auto-running)
//   clr    in  synchronous clear, overrides en
//   strobe out one-cycle pulse in the cycle the count sits at DIV-1
// After the strobe cycle the count restarts from 0, so strobes repeat every
// DIV enabled cycles, the first one DIV-1 cycles after leaving clear.
`timescale 1ns/1ps
module rate_timer #(
  parameter int DIV = 5,
  parameter int TW  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign strobe = en & w_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: step scheduler and sequencer for the up/down counter.
// Merges manual ticks with an auto-run rate timer, enforces the
// limit_lo..limit_hi window and emits at most one single-cycle step strobe.
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   tick       in  single-cycle manual step request
//   run_tog    in  single-cycle auto-run toggle
//   uphdnl     in  requested direction (1 = up)
//   count_in   in  counter value fed back from the counter
//   limit_hi   in  upper limit (unsigned)
//   limit_lo   in  lower limit (unsigned, <= limit_hi)
//   step_en    out registered step strobe
//   step_dir   out registered direction, valid with step_en
//   state_out  out FSM state (00 STOP, 01 RUN, 10 LIMIT)
//   at_limit   out current effective direction is blocked
// Build option: define COUNT_CTRL_BOUNCE_EN for ping-pong auto-run, where a
// blocked request in RUN reverses direction instead of entering LIMIT.
// Handshake: there is no back-pressure. A request (tick or timer strobe) is
// accepted in the cycle it is high unless it is dropped by blanking; step_en
// is a pure one-cycle strobe and the counter must act on it that cycle.
`timescale 1ns/1ps
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int STEP_HZ = 4,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             run_tog,
  input  logic             uphdnl,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] limit_hi,
  input  logic [WIDTH-1:0] limit_lo,
  output logic             step_en,
  output logic             step_dir,
  output logic [1:0]       state_out,
  output logic             at_limit
);

  localparam int DIV = calc_div(CLK_HZ, STEP_HZ);
  localparam int TW  = calc_tw(DIV);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_step_en;
  logic   r_step_dir;
  logic   w_step_nxt;
  logic   w_rev;
  logic   w_dir;
  logic   w_blocked;
  logic   w_strobe;
  logic   w_req;
  logic   w_tmr_en;
  logic   w_tmr_clr;

`ifdef COUNT_CTRL_BOUNCE_EN
  logic r_rev;
  logic w_rev_nxt;
  assign w_rev = r_rev;
`else
  assign w_rev = 1'b0;
`endif

  // Timer only advances in RUN; any other state holds it at zero so every
  // entry into RUN starts a fresh DIV interval.
  assign w_tmr_en  = (r_state == S_RUN);
  assign w_tmr_clr = (r_state != S_RUN);

  rate_timer #(
    .DIV (DIV),
    .TW  (TW)
  ) u_rate (
    .clk    (clk),
    .rst    (rst),
    .en     (w_tmr_en),
    .clr    (w_tmr_clr),
    .strobe (w_strobe)
  );

  assign w_dir     = uphdnl ^ w_rev;
  assign w_blocked = w_dir ? (count_in >= limit_hi) : (count_in <= limit_lo);
  assign at_limit  = w_blocked;

  // Tick and strobe merge into one request. While step_en is high count_in
  // still shows the pre-step value, so requests in that cycle are dropped.
  assign w_req = (tick | w_strobe) & ~r_step_en;

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = 1'b0;
`ifdef COUNT_CTRL_BOUNCE_EN
    w_rev_nxt   = r_rev;
`endif
    case (r_state)
      S_STOP: begin
        if (run_tog) begin
          w_state_nxt = S_RUN;
        end else if (w_req && !w_blocked) begin
          w_step_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (run_tog) begin
          w_state_nxt = S_STOP;
        end else if (w_req) begin
          if (!w_blocked) begin
            w_step_nxt = 1'b1;
          end else begin
`ifdef COUNT_CTRL_BOUNCE_EN
            w_rev_nxt = ~r_rev;
`else
            w_state_nxt = S_LIMIT;
`endif
          end
        end
      end
      S_LIMIT: begin
        // run_tog wins over the unblock check.
        if (run_tog) begin
          w_state_nxt = S_STOP;
        end else if (!w_blocked) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_STOP;
      end
    endcase
`ifdef COUNT_CTRL_BOUNCE_EN
    if (w_state_nxt == S_STOP) begin
      w_rev_nxt = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_STOP;
      r_step_en  <= 1'b0;
      r_step_dir <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step_en <= w_step_nxt;
      if (w_step_nxt) begin
        r_step_dir <= w_dir;
      end
    end
  end

`ifdef COUNT_CTRL_BOUNCE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rev <= 1'b0;
    end else begin
      r_rev <= w_rev_nxt;
    end
  end
`endif

  assign step_en   = r_step_en;
  assign step_dir  = r_step_dir;
  assign state_out = r_state;

endmodule
